csrng_app_cmd_rsp: RTL
======================

Name: csrng_app_cmd_rsp

Overview:
- Responder end of the CSRNG hardware application interface. Accepts command headers and additional-data words from one application port, tracks instantiation state, returns an ack with status, and streams 128-bit genbits for GEN commands.
- Used as a lightweight CSRNG stand-in so app-side initiators can be exercised without the full DRBG.
- Genbits come from a deterministic 128-bit state register, not a cryptographic DRBG.

Parameters:
- GenBitsW, 128, width of the genbits bus; fixed at 4 x 32.
- ReseedLimit, 32'd1024, max GEN commands between reseeds; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high (already decided)
- csrng_req_valid_i  in  1  header/data word valid
- csrng_req_ready_o  out  1  word accepted when valid&&ready
- csrng_req_bus_i  in  32  header or additional-data word
- csrng_rsp_ack_o  out  1  one-cycle command-complete pulse
- csrng_rsp_sts_o  out  1  0=ok, 1=error; valid only with ack
- genbits_valid_o  out  1  genbits block valid
- genbits_ready_i  in  1  consumer ready
- genbits_bus_o  out  128  genbits block
- genbits_fips_o  out  1  1 when the block comes from an INS-seeded state (flag0 of INS was 0)
- instantiated_o  out  1  instance status

Behaviour:
- Header fields: acmd=[2:0], rsvd=[3], clen=[7:4], flags=[11:8], glen=[24:12], rsvd=[31:25]. acmd encoding: INS=1, RES=2, GEN=3, UPD=4, UNI=5; any other code is illegal.
- Reset values: ready=0, ack=0, sts=0, genbits_valid=0, genbits_bus=0, fips=0, instantiated=0; state register cleared; FSM in IDLE. Reset mid-operation aborts any command with no ack.
- FSM states and transitions:
  - IDLE: ready=1. A header handshake latches acmd/clen/flags/glen and clears word index i. Next state: DATA if clen!=0, else PROC.
  - DATA: ready=1. Each handshake stores word i into adata[i mod 4] by XOR (adata is cleared at header) and increments i. When i==clen-1 is accepted, go to PROC. clen>12 is legal; all words are consumed.
  - PROC (1 cycle, ready=0): evaluate the error and state-update rules below.
  - GEN_OUT: genbits_valid=1 with bus=state, word0 in [31:0]. On valid&&ready, state<=state+1 (128-bit, wraps at 2^128-1 to 0) and remaining count decrements. At 0, go to ACK. Bus and valid hold stable while ready is low.
  - ACK: ack=1 for exactly one cycle, sts as decided in PROC, then IDLE.
- Error rules, checked in PROC: illegal acmd; INS while instantiated; RES/GEN/UPD/UNI-not-instantiated is OK for UNI only, error for the others. An error skips any state update and any genbits, goes straight to ACK with sts=1, and leaves the instance unchanged.
- State-update rules (no error):
  - INS: state<=adata; instantiated<=1; fips<=~flags[0].
  - RES/UPD: state<=state^adata.
  - GEN: enter GEN_OUT with count=glen; glen==0 goes directly to ACK with sts=0.
  - UNI: state<=0; instantiated<=0; fips<=0.
- Latency: header to ack = clen+3 cycles for non-GEN commands with valid held high (header, clen data, PROC, ACK).
- ready deasserts from PROC until the ack cycle completes; one command is in flight at a time.
- valid low mid-DATA simply stalls; there is no timeout.

Optional Feature:
- Macro CSRNG_APP_CMD_RSP_RESEED_CNT_EN.
- When defined: a 32-bit reseed counter is cleared by INS/RES and incremented per accepted GEN. A GEN with counter==ReseedLimit errors (sts=1, no genbits). The counter is cleared on UNI and reset.
- When undefined: no counter; GEN is never limited.

Decomposition:
- Shared package csrng_app_rsp_pkg holds:
  - header field offsets/widths;
  - acmd constants (reuse the csrng_pkg acmd_e enum values);
  - FSM state enum {IDLE, DATA, PROC, GEN_OUT, ACK};
  - GenBitsW.
- Natural sub-module: csrng_app_hdr_dec, a combinational header split plus legal-acmd check, instantiated once.

Test Plan:
- After reset, UNI (hdr 32'h5) -> ack at cycle 3, sts=0, instantiated stays 0.
- INS with clen=12 using seed words 73bec010..df5d73fa, flag0=0 -> ack after 15 cycles, sts=0, instantiated=1, fips=1. state word j = XOR of seed words i with i mod 4 == j.
- GEN with glen=2, genbits_ready toggling 1,0,1 -> first block = state (stable while ready=0), second = state+1, then a single ack with sts=0. state ends at +2.
- GEN before INS, and INS while instantiated -> ack sts=1, no genbits_valid, instance unchanged.
- Illegal acmd=7 with clen=3 -> all 3 data words consumed, then ack sts=1.
- State 128'hFFFF...FFFF with GEN glen=2 -> blocks FFFF...FFFF then 0. With CSRNG_APP_CMD_RSP_RESEED_CNT_EN defined and ReseedLimit=1: second GEN returns sts=1.

Source files
------------

// File: rtl/csrng_app_rsp_pkg.sv
// rtl/csrng_app_rsp_pkg.sv - shared header layout, command codes and FSM states for the app responder
package csrng_app_rsp_pkg;

  localparam int GenBitsW = 128;

  localparam int AcmdLsb  = 0;
  localparam int AcmdW    = 3;
  localparam int ClenLsb  = 4;
  localparam int ClenW    = 4;
  localparam int FlagsLsb = 8;
  localparam int FlagsW   = 4;
  localparam int GlenLsb  = 12;
  localparam int GlenW    = 13;

  typedef enum logic [2:0] {
    INV = 3'd0,
    INS = 3'd1,
    RES = 3'd2,
    GEN = 3'd3,
    UPD = 3'd4,
    UNI = 3'd5
  } acmd_e;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PROC,
    GEN_OUT,
    ACK
  } rsp_state_e;

endpackage

// File: rtl/csrng_app_hdr_dec.sv
// rtl/csrng_app_hdr_dec.sv - combinational command header split and legal-acmd check
module csrng_app_hdr_dec
  import csrng_app_rsp_pkg::*;
(
  input  logic [31:0]       hdr,
  output logic [AcmdW-1:0]  acmd,
  output logic [ClenW-1:0]  clen,
  output logic [FlagsW-1:0] flags,
  output logic [GlenW-1:0]  glen,
  output logic              acmd_legal
);

  assign acmd  = hdr[AcmdLsb  +: AcmdW];
  assign clen  = hdr[ClenLsb  +: ClenW];
  assign flags = hdr[FlagsLsb +: FlagsW];
  assign glen  = hdr[GlenLsb  +: GlenW];

  assign acmd_legal = (acmd == INS) || (acmd == RES) || (acmd == GEN) ||
                      (acmd == UPD) || (acmd == UNI);

  logic unused_rsvd;
  assign unused_rsvd = ^{hdr[31:25], hdr[3]};

endmodule

// File: rtl/csrng_app_cmd_rsp.sv
// rtl/csrng_app_cmd_rsp.sv - CSRNG app-interface responder with deterministic genbits state
// Optional GEN-per-reseed limit: CSRNG_APP_CMD_RSP_RESEED_CNT_EN
module csrng_app_cmd_rsp
  import csrng_app_rsp_pkg::*;
#(
  parameter logic [31:0] ReseedLimit = 32'd1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                csrng_req_valid_i,
  output logic                csrng_req_ready_o,
  input  logic [31:0]         csrng_req_bus_i,
  output logic                csrng_rsp_ack_o,
  output logic                csrng_rsp_sts_o,
  output logic                genbits_valid_o,
  input  logic                genbits_ready_i,
  output logic [GenBitsW-1:0] genbits_bus_o,
  output logic                genbits_fips_o,
  output logic                instantiated_o
);

  rsp_state_e          state_q, state_d;
  logic [AcmdW-1:0]    acmd_q;
  logic                acmd_ok_q;
  logic [ClenW-1:0]    clen_q;
  logic                flag0_q;
  logic [GlenW-1:0]    glen_q;
  logic [GlenW-1:0]    cnt_q;
  logic [ClenW-1:0]    idx_q;
  logic [31:0]         adata_q [4];
  logic [GenBitsW-1:0] drbg_q;
  logic                inst_q;
  logic                fips_q;
  logic                sts_q;
  logic                err;

  logic [AcmdW-1:0]  dec_acmd;
  logic [ClenW-1:0]  dec_clen;
  logic [FlagsW-1:0] dec_flags;
  logic [GlenW-1:0]  dec_glen;
  logic              dec_legal;

  csrng_app_hdr_dec u_hdr_dec (
    .hdr        (csrng_req_bus_i),
    .acmd       (dec_acmd),
    .clen       (dec_clen),
    .flags      (dec_flags),
    .glen       (dec_glen),
    .acmd_legal (dec_legal)
  );

  logic unused_flags;
  assign unused_flags = ^dec_flags[FlagsW-1:1];

  logic req_hs, gen_hs;
  assign req_hs = csrng_req_valid_i && csrng_req_ready_o;
  assign gen_hs = genbits_valid_o && genbits_ready_i;

`ifdef CSRNG_APP_CMD_RSP_RESEED_CNT_EN
  logic [31:0] reseed_cnt_q;
  logic        reseed_hit;
  assign reseed_hit = (reseed_cnt_q == ReseedLimit);
`else
  logic reseed_hit;
  assign reseed_hit = 1'b0;
  logic unused_limit;
  assign unused_limit = ^ReseedLimit;
`endif

  // Errors leave the instance untouched; UNI on an empty instance is harmless.
  always_comb begin
    err = 1'b0;
    if (!acmd_ok_q) begin
      err = 1'b1;
    end else begin
      case (acmd_q)
        INS:           err = inst_q;
        RES, UPD:      err = !inst_q;
        GEN:           err = !inst_q || reseed_hit;
        default:       err = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d           = state_q;
    csrng_req_ready_o = 1'b0;
    csrng_rsp_ack_o   = 1'b0;
    genbits_valid_o   = 1'b0;
    case (state_q)
      IDLE: begin
        csrng_req_ready_o = 1'b1;
        if (csrng_req_valid_i) state_d = (dec_clen != '0) ? DATA : PROC;
      end
      DATA: begin
        csrng_req_ready_o = 1'b1;
        if (csrng_req_valid_i && (idx_q == clen_q - 4'd1)) state_d = PROC;
      end
      PROC: begin
        state_d = (!err && (acmd_q == GEN) && (glen_q != '0)) ? GEN_OUT : ACK;
      end
      GEN_OUT: begin
        genbits_valid_o = 1'b1;
        if (genbits_ready_i && (cnt_q == 13'd1)) state_d = ACK;
      end
      ACK: begin
        csrng_rsp_ack_o = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) csrng_req_ready_o = 1'b0;
  end

  assign csrng_rsp_sts_o = csrng_rsp_ack_o & sts_q;
  assign genbits_bus_o   = genbits_valid_o ? drbg_q : '0;
  assign genbits_fips_o  = fips_q;
  assign instantiated_o  = inst_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acmd_q    <= '0;
      acmd_ok_q <= 1'b0;
      clen_q    <= '0;
      flag0_q   <= 1'b0;
      glen_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      drbg_q    <= '0;
      inst_q    <= 1'b0;
      fips_q    <= 1'b0;
      sts_q     <= 1'b0;
      for (int k = 0; k < 4; k++) adata_q[k] <= '0;
`ifdef CSRNG_APP_CMD_RSP_RESEED_CNT_EN
      reseed_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_hs) begin
        acmd_q    <= dec_acmd;
        acmd_ok_q <= dec_legal;
        clen_q    <= dec_clen;
        flag0_q   <= dec_flags[0];
        glen_q    <= dec_glen;
        idx_q     <= '0;
        for (int k = 0; k < 4; k++) adata_q[k] <= '0;
      end
      // Words beyond four fold back onto the same lanes.
      if (state_q == DATA && req_hs) begin
        adata_q[idx_q[1:0]] <= adata_q[idx_q[1:0]] ^ csrng_req_bus_i;
        idx_q               <= idx_q + 4'd1;
      end
      if (state_q == PROC) begin
        sts_q <= err;
        cnt_q <= glen_q;
        if (!err) begin
          case (acmd_q)
            INS: begin
              drbg_q <= {adata_q[3], adata_q[2], adata_q[1], adata_q[0]};
              inst_q <= 1'b1;
              fips_q <= ~flag0_q;
`ifdef CSRNG_APP_CMD_RSP_RESEED_CNT_EN
              reseed_cnt_q <= '0;
`endif
            end
            RES: begin
              drbg_q <= drbg_q ^ {adata_q[3], adata_q[2], adata_q[1], adata_q[0]};
`ifdef CSRNG_APP_CMD_RSP_RESEED_CNT_EN
              reseed_cnt_q <= '0;
`endif
            end
            UPD: drbg_q <= drbg_q ^ {adata_q[3], adata_q[2], adata_q[1], adata_q[0]};
            UNI: begin
              drbg_q <= '0;
              inst_q <= 1'b0;
              fips_q <= 1'b0;
`ifdef CSRNG_APP_CMD_RSP_RESEED_CNT_EN
              reseed_cnt_q <= '0;
`endif
            end
            GEN: begin
`ifdef CSRNG_APP_CMD_RSP_RESEED_CNT_EN
              reseed_cnt_q <= reseed_cnt_q + 32'd1;
`endif
            end
            default: ;
          endcase
        end
      end
      if (state_q == GEN_OUT && gen_hs) begin
        drbg_q <= drbg_q + 128'd1;
        cnt_q  <= cnt_q - 13'd1;
      end
    end
  end

endmodule
